// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control pulses and BCD/status outputs of the stopwatch core
interface stopwatch_counter_if;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic       running;
   logic       ovf;

   modport master (
      output start_stop, clear, lap,
      input  d0, d1, d2, d3, running, ovf
   );

   modport slave (
      input  start_stop, clear, lap,
      output d0, d1, d2, d3, running, ovf
   );
endinterface

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - 10 ms prescaler, SS.hh BCD counter and run/pause/clear FSM; optional lap hold under LAP_HOLD_EN
module stopwatch_counter #(
   parameter int TICK_DIV = 1000000
) (
   input  logic                clk,
   input  logic                resetclk,
   stopwatch_counter_if.slave  sw_if
);

   localparam int            CW      = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CTR_MAX = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_MAXED = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_ctr;
   logic          r_tick;
   logic          w_tick;
   logic [15:0]   r_cnt;
   logic [15:0]   w_cnt_inc;
   logic [15:0]   w_cnt_nxt;
   logic          w_all9;
   logic          r_running;
   logic          r_ovf;

   // The tick is registered once before it reaches the digits, so the first
   // increment lands TICK_DIV+1 edges after RUN is entered. A tick already in
   // that pipeline is still counted if the FSM pauses in the same cycle.
   assign w_tick = (r_state == S_RUN) && (r_ctr == CTR_MAX);
   assign w_all9 = (r_cnt == 16'h9999);

   // BCD ripple increment, every carry resolved in one cycle
   always_comb begin
      logic carry;
      carry     = 1'b1;
      w_cnt_inc = r_cnt;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r_cnt[4*i +: 4] == 4'd9) begin
               w_cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Next count: clear drops any pending tick, 99.99 saturates instead of wrapping
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (sw_if.clear) begin
         w_cnt_nxt = 16'h0000;
      end else if (r_tick && !w_all9) begin
         w_cnt_nxt = w_cnt_inc;
      end
   end

   // Next-state logic: clear first, then saturation, then start/stop toggling
   always_comb begin
      w_state_nxt = r_state;
      if (sw_if.clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sw_if.start_stop) w_state_nxt = S_RUN;
            end
            S_RUN: begin
               if (r_tick && w_all9)       w_state_nxt = S_MAXED;
               else if (sw_if.start_stop)  w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
               if (r_tick && w_all9)       w_state_nxt = S_MAXED;
               else if (sw_if.start_stop)  w_state_nxt = S_RUN;
            end
            S_MAXED: begin
               w_state_nxt = S_MAXED;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Prescaler: counts in RUN, holds the fraction in PAUSE, zero elsewhere
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) begin
         r_ctr <= '0;
      end else if (sw_if.clear) begin
         r_ctr <= '0;
      end else if (r_state == S_RUN) begin
         r_ctr <= (r_ctr == CTR_MAX) ? '0 : r_ctr + CW'(1);
      end else if (r_state != S_PAUSE) begin
         r_ctr <= '0;
      end
   end

   // Tick pipeline stage; a tick coincident with clear is discarded
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) r_tick <= 1'b0;
      else          r_tick <= w_tick && !sw_if.clear;
   end

   // Live BCD count
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) r_cnt <= 16'h0000;
      else          r_cnt <= w_cnt_nxt;
   end

   // Status flags registered from the next state so they align with it
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) begin
         r_running <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_running <= (w_state_nxt == S_RUN);
         r_ovf     <= (w_state_nxt == S_MAXED);
      end
   end

   assign sw_if.running = r_running;
   assign sw_if.ovf     = r_ovf;

`ifdef LAP_HOLD_EN
   logic        r_hold;
   logic        w_hold_nxt;
   logic [15:0] r_dout;

   // Lap toggles hold only in RUN or PAUSE; clear always releases it
   always_comb begin
      w_hold_nxt = r_hold;
      if (sw_if.clear) begin
         w_hold_nxt = 1'b0;
      end else if (sw_if.lap && (r_state == S_RUN || r_state == S_PAUSE)) begin
         w_hold_nxt = ~r_hold;
      end
   end

   // Hold flag
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) r_hold <= 1'b0;
      else          r_hold <= w_hold_nxt;
   end

   // Displayed digits: snapshot on hold rise, frozen while held, else live
   always_ff @(posedge clk or posedge resetclk) begin
      if (resetclk) begin
         r_dout <= 16'h0000;
      end else if (w_hold_nxt) begin
         if (!r_hold) r_dout <= r_cnt;
      end else begin
         r_dout <= w_cnt_nxt;
      end
   end

   assign sw_if.d0 = r_dout[3:0];
   assign sw_if.d1 = r_dout[7:4];
   assign sw_if.d2 = r_dout[11:8];
   assign sw_if.d3 = r_dout[15:12];
`else
   logic w_lap_unused;
   assign w_lap_unused = sw_if.lap;

   assign sw_if.d0 = r_cnt[3:0];
   assign sw_if.d1 = r_cnt[7:4];
   assign sw_if.d2 = r_cnt[11:8];
   assign sw_if.d3 = r_cnt[15:12];
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - scoreboard bench for stopwatch_counter with TICK_DIV=4
module tb_stopwatch_counter;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic resetclk;
   int   cyc     = 0;
   int   n_total = 0;
   int   n_bad   = 0;
   bit   mon_en  = 1'b0;
   logic [15:0] prev = 16'h0000;
   logic [15:0] digits;

   typedef struct {
      string       tag;
      logic [15:0] val;
      int          at;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;

   stopwatch_counter_if sw_if ();

   stopwatch_counter #(.TICK_DIV(TD)) u_dut (
      .clk      (clk),
      .resetclk (resetclk),
      .sw_if    (sw_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign digits = {sw_if.d3, sw_if.d2, sw_if.d1, sw_if.d0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] bcd(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   task automatic push(input string tag, input int n, input int at);
      exp_t e;
      e.tag = tag;
      e.val = bcd(n);
      e.at  = at;
      sb.push_back(e);
   endtask

   // every change of the displayed digits must match the next scoreboard entry
   always @(negedge clk) begin
      if (mon_en && digits !== prev) begin
         if (sb.size() == 0) begin
            chk("spurious_change", {16'h0, digits}, {16'h0, prev});
         end else begin
            m_e = sb.pop_front();
            chk({m_e.tag, "_val"}, {16'h0, digits}, {16'h0, m_e.val});
            chk({m_e.tag, "_cyc"}, cyc, m_e.at);
         end
      end
      prev = digits;
   end

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse(input bit ss, input bit clr, input bit lp);
      sw_if.start_stop = ss;
      sw_if.clear      = clr;
      sw_if.lap        = lp;
      @(posedge clk);
      #2;
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.lap        = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk({tag, "_drain"}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_clear(input string tag);
      push(tag, 0, cyc + 1);
      pulse(1'b0, 1'b1, 1'b0);
      chk({tag, "_run"}, sw_if.running, 1'b0);
      chk({tag, "_ovf"}, sw_if.ovf, 1'b0);
      drain(tag, 4);
   endtask

   initial begin
      int e0;
      int r0;
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.lap        = 1'b0;
      resetclk         = 1'b0;
      #1 resetclk = 1'b1;
      #1;
      chk("rst_digits", {16'h0, digits}, 32'h0);
      chk("rst_running", sw_if.running, 1'b0);
      chk("rst_ovf", sw_if.ovf, 1'b0);
      @(posedge clk);
      #2 resetclk = 1'b0;
      mon_en = 1'b1;
      go_to(cyc + 10);
      chk("idle_running", sw_if.running, 1'b0);

      // run to 12.34 then hit asynchronous reset mid-cycle
      e0 = cyc + 1;
      for (int n = 1; n <= 1234; n++) push("s1", n, e0 + 1 + TD * n);
      pulse(1'b1, 1'b0, 1'b0);
      chk("s1_running", sw_if.running, 1'b1);
      go_to(e0 + 2 + TD * 1234);
      chk("s1_q_empty", sb.size(), 0);
      chk("s1_at_1234", {16'h0, digits}, 32'h1234);
      mon_en   = 1'b0;
      resetclk = 1'b1;
      #1;
      chk("s1_rst_digits", {16'h0, digits}, 32'h0);
      chk("s1_rst_running", sw_if.running, 1'b0);
      chk("s1_rst_ovf", sw_if.ovf, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 resetclk = 1'b0;
      mon_en = 1'b1;

      // carry chain up to 10.00, first increment exactly 5 edges after start
      e0 = cyc + 1;
      for (int n = 1; n <= 1000; n++) push("s2", n, e0 + 1 + TD * n);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(e0 + 4);
      chk("s2_no_early_tick", {16'h0, digits}, 32'h0);
      go_to(e0 + 1 + TD * 999);
      chk("s2_0999", {16'h0, digits}, 32'h0999);
      go_to(e0 + 1 + TD * 1000);
      chk("s2_1000", {16'h0, digits}, 32'h1000);
      drain("s2", 8);
      do_clear("s2_clr");

      // pause two cycles into a tick period, resume, tick after 2+1
      e0 = cyc + 1;
      push("s3", 1, e0 + 5);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(e0 + 5);
      pulse(1'b1, 1'b0, 1'b0);
      chk("s3_paused", sw_if.running, 1'b0);
      go_to(cyc + 50);
      chk("s3_hold_digits", {16'h0, digits}, 32'h0001);
      r0 = cyc + 1;
      push("s3", 2, r0 + 3);
      push("s3", 3, r0 + 3 + TD);
      pulse(1'b1, 1'b0, 1'b0);
      chk("s3_resumed", sw_if.running, 1'b1);
      go_to(r0 + 2);
      chk("s3_not_early", {16'h0, digits}, 32'h0001);
      go_to(r0 + 3 + TD);
      drain("s3", 4);
      do_clear("s3_clr");

      // saturation at 99.99
      e0 = cyc + 1;
      for (int n = 1; n <= 9999; n++) push("s4", n, e0 + 1 + TD * n);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(e0 + TD * 10000);
      chk("s4_pre_ovf", sw_if.ovf, 1'b0);
      chk("s4_pre_run", sw_if.running, 1'b1);
      chk("s4_9999", {16'h0, digits}, 32'h9999);
      go_to(e0 + 1 + TD * 10000);
      chk("s4_ovf", sw_if.ovf, 1'b1);
      chk("s4_run", sw_if.running, 1'b0);
      chk("s4_stays", {16'h0, digits}, 32'h9999);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(cyc + 20);
      chk("s4_ss_ignored_ovf", sw_if.ovf, 1'b1);
      chk("s4_ss_ignored_run", sw_if.running, 1'b0);
      drain("s4", 4);
      do_clear("s4_clr");

      // clear together with start_stop during RUN
      e0 = cyc + 1;
      push("s5a", 1, e0 + 5);
      push("s5a", 2, e0 + 9);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(e0 + 9);
      drain("s5a", 4);
      push("s5_clr_ss", 0, cyc + 1);
      pulse(1'b1, 1'b1, 1'b0);
      chk("s5_clr_ss_run", sw_if.running, 1'b0);
      chk("s5_clr_ss_digits", {16'h0, digits}, 32'h0);
      go_to(cyc + 10);
      chk("s5_stays_idle", sw_if.running, 1'b0);
      drain("s5_clr_ss", 4);

      // start_stop on the tick cycle at 00.05
      e0 = cyc + 1;
      for (int n = 1; n <= 6; n++) push("s5b", n, e0 + 1 + TD * n);
      pulse(1'b1, 1'b0, 1'b0);
`ifndef LAP_HOLD_EN
      go_to(e0 + 10);
      pulse(1'b0, 1'b0, 1'b1);
`endif
      go_to(e0 + 23);
      pulse(1'b1, 1'b0, 1'b0);
      chk("s5b_paused", sw_if.running, 1'b0);
      chk("s5b_0005", {16'h0, digits}, 32'h0005);
      go_to(e0 + 25);
      chk("s5b_0006", {16'h0, digits}, 32'h0006);
      go_to(e0 + 45);
      chk("s5b_still_paused", sw_if.running, 1'b0);
      drain("s5b", 4);
      do_clear("s5b_clr");

`ifdef LAP_HOLD_EN
      // lap hold at 00.20, release shows live 00.30
      e0 = cyc + 1;
      for (int n = 1; n <= 20; n++) push("s6", n, e0 + 1 + TD * n);
      pulse(1'b1, 1'b0, 1'b0);
      go_to(e0 + 1 + TD * 20);
      pulse(1'b0, 1'b0, 1'b1);
      go_to(e0 + 122);
      chk("s6_held", {16'h0, digits}, 32'h0020);
      chk("s6_running", sw_if.running, 1'b1);
      push("s6", 30, e0 + 123);
      pulse(1'b0, 1'b0, 1'b1);
      chk("s6_live", {16'h0, digits}, 32'h0030);
      drain("s6", 4);
      do_clear("s6_clr");
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog_timeout got=cyc%0d exp=finish", cyc);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end
endmodule
